// File: rtl/processor_pkg.sv
// Shared definitions for the 8-bit accumulator processor.
// Contents: default widths, opcode encodings, control-FSM state type and
// a helper that flags opcodes whose execute cycle addresses RAM by IR[4:0].
package processor_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAITIN,
    S_HALT
  } state_e;

  // Opcodes whose EXEC cycle puts the operand address on the RAM bus.
  function automatic logic uses_operand(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/processor_if.sv
// User-side bus of the processor: mode/strobe/switch inputs and the
// output/debug observation signals.
// master: the environment (drives init, enter, in; observes the rest).
// slave:  the processor.
interface processor_if import processor_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              init;        // 1 = memory-load mode, 0 = run
  logic              enter;       // user strobe, rising edge = press
  logic [DATA_W-1:0] in;          // switch data
  logic [DATA_W-1:0] out;         // output port (= A)
  logic              halt;        // high while halted
  logic [ADDR_W-1:0] IR40;        // IR operand field
  logic [ADDR_W-1:0] MeminstOut;  // current RAM address
  logic [DATA_W-1:0] regAOut;     // accumulator
  logic [DATA_W-1:0] RAMout;      // RAM read data at MeminstOut

  modport master (
    output init, enter, in,
    input  out, halt, IR40, MeminstOut, regAOut, RAMout
  );

  modport slave (
    input  init, enter, in,
    output out, halt, IR40, MeminstOut, regAOut, RAMout
  );
endinterface

// File: rtl/processor_ram.sv
// Unified program/data RAM: 2**ADDR_W words of DATA_W bits,
// asynchronous read, synchronous write, no reset.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port.
module processor_ram #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/processor.sv
// 8-bit accumulator processor: control FSM and datapath (PC, IR, A, load
// pointer) around a unified program/data RAM.
// Ports: clk, reset (async, active low), bus (processor_if.slave) carrying
// init/enter/in and the out/halt/debug outputs.
// Build option PROCESSOR_INPUT_SYNC_EN: when defined, enter and init pass
// through 2-flop synchronizers before use (2 extra cycles of latency).
module processor import processor_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic        clk,
  input logic        reset,
  processor_if.slave bus
);

  logic w_enter;
  logic w_init;

`ifdef PROCESSOR_INPUT_SYNC_EN
  logic [1:0] r_enter_sync;
  logic [1:0] r_init_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enter_sync <= '0;
      r_init_sync  <= '0;
    end else begin
      r_enter_sync <= {r_enter_sync[0], bus.enter};
      r_init_sync  <= {r_init_sync[0], bus.init};
    end
  end

  assign w_enter = r_enter_sync[1];
  assign w_init  = r_init_sync[1];
`else
  assign w_enter = bus.enter;
  assign w_init  = bus.init;
`endif

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_pc, w_pc_d;
  logic [ADDR_W-1:0] r_lp, w_lp_d;
  logic [DATA_W-1:0] r_ir, w_ir_d;
  logic [DATA_W-1:0] r_a, w_a_d;
  logic              r_enter_q;

  logic              w_press;
  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_opaddr;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  assign w_press  = w_enter & ~r_enter_q;
  assign w_op     = r_ir[DATA_W-1 -: 3];
  assign w_opaddr = r_ir[ADDR_W-1:0];

  // One shared address bus serves both read and write.
  always_comb begin
    w_addr = r_pc;
    case (r_state)
      S_LOAD:  w_addr = r_lp;
      S_EXEC:  if (uses_operand(w_op)) w_addr = w_opaddr;
      default: ;
    endcase
  end

  processor_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_addr),
    .i_wdata(w_wdata),
    .i_raddr(w_addr),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_lp_d    = r_lp;
    w_ir_d    = r_ir;
    w_a_d     = r_a;
    w_we      = 1'b0;
    w_wdata   = r_a;

    // init overrides everything; an in-flight instruction is dropped.
    if (w_init) begin
      w_state_d = S_LOAD;
      if (r_state != S_LOAD) begin
        w_lp_d = '0;
        w_pc_d = '0;
      end else if (w_press) begin
        w_we    = 1'b1;
        w_wdata = bus.in;
        w_lp_d  = r_lp + 1'b1;
      end
    end else begin
      unique case (r_state)
        S_LOAD: begin
          w_state_d = S_FETCH;
          w_pc_d    = '0;
        end
        S_FETCH: begin
          w_ir_d    = w_rdata;
          w_pc_d    = r_pc + 1'b1;
          w_state_d = S_DECODE;
        end
        S_DECODE: begin
          w_state_d = (w_op == OP_HALT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          w_state_d = S_FETCH;
          unique case (w_op)
            OP_LOAD:  w_a_d = w_rdata;
            OP_STORE: w_we  = 1'b1;
            OP_ADD:   w_a_d = r_a + w_rdata;
            OP_SUB:   w_a_d = r_a - w_rdata;
            OP_IN:    w_state_d = S_WAITIN;
            OP_JZ:    if (r_a == '0) w_pc_d = w_opaddr;
            OP_JPOS:  if (!r_a[DATA_W-1] && (r_a != '0)) w_pc_d = w_opaddr;
            OP_HALT:  w_state_d = S_HALT;
          endcase
        end
        S_WAITIN: begin
          if (w_press) begin
            w_a_d     = bus.in;
            w_state_d = S_FETCH;
          end
        end
        S_HALT:  w_state_d = S_HALT;
        default: w_state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_lp      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_enter_q <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_lp      <= w_lp_d;
      r_ir      <= w_ir_d;
      r_a       <= w_a_d;
      r_enter_q <= w_enter;
    end
  end

  assign bus.out        = r_a;
  assign bus.regAOut    = r_a;
  assign bus.halt       = (r_state == S_HALT);
  assign bus.IR40       = w_opaddr;
  assign bus.MeminstOut = w_addr;
  assign bus.RAMout     = w_rdata;

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: loads directed and random programs,
// runs them against an instruction-level model of the ISA and reads RAM
// back through the load-mode address bus.
module tb_processor;

  logic clk = 1'b0;
  logic reset;

  processor_if bus_if ();

  processor u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instruction-level reference state.
  logic [7:0] m_mem [32];
  logic [7:0] m_a;
  int         m_pc;
  logic [7:0] p_img [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one non-IN, non-HALT instruction.
  function automatic void model_exec(input logic [7:0] instr);
    int op = int'(instr) / 32;
    int a  = int'(instr) % 32;
    m_pc = (m_pc + 1) % 32;
    case (op)
      0: m_a = m_mem[a];
      1: m_mem[a] = m_a;
      2: m_a = m_a + m_mem[a];
      3: m_a = m_a - m_mem[a];
      5: if (m_a == 0) m_pc = a;
      6: if (m_a != 0 && m_a < 128) m_pc = a;
      default: ;
    endcase
  endfunction

  // Called in LOAD state with LP=0: optionally verifies the old contents,
  // writes p_img into all 32 words, then drops init to start the run.
  task automatic load_mem(input bit check_old);
    for (int a = 0; a < 32; a++) begin
      if (check_old) check_eq("mem_readback", bus_if.RAMout, m_mem[a]);
      check_eq("load_ptr", bus_if.MeminstOut, a);
      bus_if.in    = p_img[a];
      bus_if.enter = 1'b1;
      tick();
      bus_if.enter = 1'b0;
      tick();
      m_mem[a] = p_img[a];
    end
    check_eq("load_ptr_wrap", bus_if.MeminstOut, 0);
    bus_if.init = 1'b0;
    tick();
    m_pc = 0;
    check_eq("pc_restart", bus_if.MeminstOut, 0);
    check_eq("run_halt", bus_if.halt, 0);
    check_eq("a_kept", bus_if.regAOut, m_a);
  endtask

  // Runs up to max_steps instructions. abort_step >= 0 raises init at that
  // instruction after abort_cyc cycles (random if negative). Always leaves
  // the DUT in LOAD state with init=1.
  task automatic run_prog(input int max_steps, input int abort_step, input int abort_cyc,
                          input int first_in, input int first_stall, input bit reset_in_halt);
    logic [7:0] instr;
    logic [7:0] v;
    int op;
    int c;
    int k;
    bit first = 1'b1;
    for (int s = 0; s < max_steps; s++) begin
      instr = m_mem[m_pc];
      op    = int'(instr) / 32;
      if (s == abort_step) begin
        c = abort_cyc;
        if (c < 0) c = (op == 4) ? $urandom_range(0, 3) : $urandom_range(0, 2);
        repeat (c) tick();
        bus_if.init = 1'b1;
        tick();
        check_eq("abort_halt", bus_if.halt, 0);
        check_eq("abort_lp", bus_if.MeminstOut, 0);
        check_eq("abort_a", bus_if.regAOut, m_a);
        return;
      end
      if (op == 7) begin
        repeat (2) tick();
        check_eq("halt_set", bus_if.halt, 1);
        check_eq("halt_ir40", bus_if.IR40, int'(instr) % 32);
        check_eq("halt_pc", bus_if.MeminstOut, (m_pc + 1) % 32);
        repeat (2) begin
          bus_if.in    = 8'($urandom);
          bus_if.enter = 1'b1;
          tick();
          bus_if.enter = 1'b0;
          tick();
        end
        check_eq("halt_sticky", bus_if.halt, 1);
        check_eq("halt_a", bus_if.regAOut, m_a);
        check_eq("halt_sticky_pc", bus_if.MeminstOut, (m_pc + 1) % 32);
        if (reset_in_halt) begin
          #2 reset = 1'b0;
          #1;
          check_eq("async_rst_halt", bus_if.halt, 0);
          check_eq("async_rst_a", bus_if.regAOut, 0);
          check_eq("async_rst_ir40", bus_if.IR40, 0);
          m_a = 8'h00;
          bus_if.init = 1'b1;
          reset = 1'b1;
        end
        bus_if.init = 1'b1;
        tick();
        return;
      end
      repeat (3) tick();
      if (op == 4) begin
        k = first ? first_stall : $urandom_range(0, 4);
        v = (first && first_in >= 0) ? 8'(first_in) : 8'($urandom);
        repeat (k) tick();
        if (k > 0) begin
          check_eq("in_stall_a", bus_if.regAOut, m_a);
          check_eq("in_stall_halt", bus_if.halt, 0);
        end
        bus_if.in    = v;
        bus_if.enter = 1'b1;
        tick();
        bus_if.enter = 1'b0;
        m_a  = v;
        m_pc = (m_pc + 1) % 32;
        first = 1'b0;
      end else begin
        model_exec(instr);
      end
      check_eq("step_a", bus_if.regAOut, m_a);
      check_eq("step_out", bus_if.out, m_a);
      check_eq("step_ir40", bus_if.IR40, int'(instr) % 32);
      check_eq("step_pc", bus_if.MeminstOut, m_pc);
      check_eq("step_halt", bus_if.halt, 0);
    end
    bus_if.init = 1'b1;
    tick();
  endtask

  task automatic clear_img();
    for (int a = 0; a < 32; a++) p_img[a] = 8'h00;
  endtask

  task automatic random_img();
    int op;
    for (int a = 0; a < 32; a++) begin
      op = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 6);
      p_img[a] = 8'(op * 32 + $urandom_range(0, 31));
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus_if.init  = 1'b1;
    bus_if.enter = 1'b0;
    bus_if.in    = 8'h00;
    m_a          = 8'h00;
    m_pc         = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_halt", bus_if.halt, 0);
    check_eq("rst_out", bus_if.out, 0);
    check_eq("rst_a", bus_if.regAOut, 0);
    check_eq("rst_ir40", bus_if.IR40, 0);
    check_eq("rst_pc", bus_if.MeminstOut, 0);
    reset = 1'b1;
    tick();

    // IN 0; ADD 6; STORE 7; HALT; data 0,0,5. Input 7 after a 20-cycle stall.
    clear_img();
    p_img[0] = 8'h80; p_img[1] = 8'h46; p_img[2] = 8'h27; p_img[3] = 8'hE0;
    p_img[6] = 8'h05;
    load_mem(1'b0);
    run_prog(20, -1, -1, 7, 20, 1'b0);
    check_eq("spec_a_12", bus_if.regAOut, 12);

    // IN 0 (3); SUB 12 (5); JPOS 0; JZ 0; LOAD 13 (0); JZ 9; ... 9: HALT.
    clear_img();
    p_img[0] = 8'h80; p_img[1] = 8'h6C; p_img[2] = 8'hC0; p_img[3] = 8'hA0;
    p_img[4] = 8'h0D; p_img[5] = 8'hA9; p_img[9] = 8'hE0;
    p_img[12] = 8'h05; p_img[13] = 8'h00;
    load_mem(1'b1);
    run_prog(20, -1, -1, 3, 2, 1'b1);

    // STORE abandoned in its EXEC cycle by init.
    clear_img();
    p_img[0] = 8'h14; p_img[1] = 8'h35; p_img[2] = 8'hE0;
    p_img[20] = 8'h55; p_img[21] = 8'hAA;
    load_mem(1'b1);
    run_prog(20, 1, 2, -1, 0, 1'b0);

    // init raised while waiting in IN.
    clear_img();
    p_img[0] = 8'h80; p_img[1] = 8'h35; p_img[2] = 8'hE0; p_img[21] = 8'h3C;
    load_mem(1'b1);
    run_prog(20, 0, 3, -1, 4, 1'b0);

    for (int r = 0; r < 20; r++) begin
      random_img();
      load_mem(1'b1);
      run_prog(25, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 24) : -1, -1, -1,
               $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    random_img();
    load_mem(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/processor.md
Name: processor

Overview:
- 8-bit accumulator processor with a 32x8 unified program/data RAM, 5-bit PC, 8-bit IR and accumulator A.
- Two operating modes:
  - init=1: memory-load mode. Each enter press writes `in` to consecutive RAM addresses starting at 0.
  - init=0: the processor runs from address 0 until it reaches HALT.
- Debug ports expose the IR operand field, the current RAM address, A and the RAM read data.

Parameters:
- ADDR_W, 5, RAM address / PC width (RAM depth = 2**ADDR_W = 32)
- DATA_W, 8, data, IR, A and I/O width

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- init  in  1  1 = memory-load mode; 0 = run
- enter  in  1  user strobe; rising edge (registered edge detect) = one "press"
- in  in  8  switch data; used for memory load and for the IN instruction
- out  out  8  output port; always equal to A
- halt  out  1  1 while in HALT state
- IR40  out  5  IR[4:0] (operand address field)
- MeminstOut  out  5  current RAM address bus
- regAOut  out  8  accumulator A
- RAMout  out  8  RAM read data at MeminstOut (combinational)

Behaviour:
- Instruction word: IR[7:5] = opcode, IR[4:0] = address aaaaa.
- Opcodes:
  - 000 LOAD: A<=M[a]
  - 001 STORE: M[a]<=A
  - 010 ADD: A<=A+M[a]
  - 011 SUB: A<=A-M[a]
  - 100 IN: wait for an enter press, then A<=in
  - 101 JZ: if A==0 then PC<=a
  - 110 JPOS: if A[7]==0 and A!=0 then PC<=a
  - 111 HALT
- Arithmetic is 8-bit two's complement, wraps modulo 256, with no flags.
- RAM:
  - asynchronous read, synchronous write
  - not cleared by reset
- enter edge detect: press = enter & ~enter_q, where enter_q is a flop reset to 0.
- States: LOAD, FETCH, DECODE, EXEC, WAITIN, HALT.
- Reset (reset==0):
  - A=0, PC=0, IR=0, load pointer LP=0, enter_q=0
  - state=FETCH; halt=0; out=0
- init==1 has priority over all other states, checked every cycle:
  - go to LOAD; set LP=0 and PC=0 on entry.
  - In LOAD, each press writes M[LP]<=in and LP<=LP+1; LP wraps 31->0.
- LOAD with init==0: go to FETCH with PC=0. A is unchanged.
- FETCH: IR<=M[PC], PC<=PC+1 (wraps 31->0), next state DECODE.
- DECODE: next state EXEC. A decoded HALT goes directly to HALT.
- EXEC: performs the op in 1 cycle, then FETCH.
  - IN goes to WAITIN instead.
  - Each non-IN instruction takes 3 cycles total.
- WAITIN:
  - on a press: A<=in, then FETCH
  - otherwise stay in WAITIN
  - Multiple presses during a single cycle are impossible. Only a press that occurs in WAITIN counts; earlier presses are not queued.
- HALT:
  - halt=1; remains until reset, or until init=1 (which goes to LOAD)
  - presses are ignored
- MeminstOut:
  - LOAD: LP
  - FETCH: PC
  - EXEC with LOAD/STORE/ADD/SUB: IR[4:0]
  - otherwise: PC
- STORE to the address of a later instruction is allowed (self-modifying code).
- init asserted mid-instruction (including WAITIN): the instruction is abandoned, and no write occurs in that cycle.

Optional Feature:
- Macro: PROCESSOR_INPUT_SYNC_EN.
- Defined: enter and init each pass through a 2-flop synchronizer (reset to 0) before use. This adds 2 cycles of latency to press detection and mode changes.
- Undefined: enter and init are used directly; enter still goes through the edge-detect flop.

Decomposition:
- Package processor_pkg contains:
  - opcode localparams (OP_LOAD..OP_HALT)
  - state enum (S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_WAITIN, S_HALT)
  - ADDR_W and DATA_W defaults
- One sub-module, processor_ram: 32x8 RAM with async read and sync write (we, waddr, wdata, raddr, rdata).
- Control FSM and datapath stay in processor.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> halt=0, out=0, regAOut=0, IR40=0.
- Load and run:
  - Load with init=1 and 7 presses: 100_00000, 010_00110, 001_00111, 111_00000, 0, 0, 5.
  - Then init=0 with in=7 and one press while in WAITIN.
  - Expect: regAOut=12, out=12, M[7]=12 (RAMout=12 when MeminstOut=7), halt=1, IR40=0.
- IN stall: run IN with no press for 20 cycles -> A unchanged, halt=0. A press then updates A in the next cycle.
- SUB wrap and JPOS:
  - A=3, SUB of M=5 -> A=8'hFE.
  - JPOS not taken; JZ not taken.
  - After LOAD 0, JZ to address 4 -> PC=4.
- init mid-run: assert init during WAITIN -> LOAD state, no write occurs, halt=0. Then init=0 -> PC restarts at 0.
- HALT sticky: enter presses while halt=1 -> all state unchanged; reset clears halt within the same cycle (asynchronous).
